nvram_ioctl_upload: RTL and testbench
=====================================

Name: nvram_ioctl_upload

Overview:
- HPS-facing NVRAM server for the arcade core's 64-byte high-score EAROM.
- The game CPU reads and writes the store through a local port.
- HPS restores the store through the ioctl download path (writer side).
- HPS saves the store through the ioctl upload path (reader side). This block is the responder that feeds ioctl_din.
- Tracks dirty state and raises a save request once the game has stopped writing.

Parameters:
AW, 6, address width of store (DEPTH = 2^AW bytes)
NV_INDEX, 8'd4, ioctl_index value selecting NVRAM for download/upload
IDLE_FRAMES, 60, vblank rising edges of write-silence before save_req (1..255)

Ports:
clk_sys  in  1  system clock (hps_io clock domain)
reset  in  1  synchronous, active-high
ea_addr  in  AW  game-side address
ea_din  in  8  game-side write data
ea_wr  in  1  game-side write strobe, one byte per cycle when high
ea_dout  out  8  game-side read data, registered, valid 1 cycle after ea_addr
vblank  in  1  video vblank, used for frame counting
ioctl_download  in  1  hps_io download active
ioctl_upload  in  1  hps_io upload active
ioctl_index  in  8  hps_io file index
ioctl_wr  in  1  download byte strobe
ioctl_rd  in  1  upload byte request strobe
ioctl_addr  in  25  byte address for download/upload
ioctl_dout  in  8  download byte
ioctl_din  out  8  upload byte returned to hps_io
dirty  out  1  store differs from last saved/restored image
save_req  out  1  one-cycle pulse requesting HPS autosave
restored  out  1  a complete NVRAM restore has finished since reset

Behaviour:
- Storage: true dual-port RAM. Port A is game-side. Port B is ioctl-side. Contents are not cleared by reset. Power-up contents are 0xFF.
- Reset values: ea_dout=0, ioctl_din=0xFF, dirty=0, save_req=0, restored=0, frame counter=0, FSM=IDLE.
- sel = (ioctl_index==NV_INDEX). in_range = (ioctl_addr[24:AW]==0).

FSM states: IDLE, RESTORE, UPLOAD.
- IDLE->RESTORE when ioctl_download & sel.
- IDLE->UPLOAD when ioctl_upload & sel.
- RESTORE->IDLE when ioctl_download falls. That cycle sets restored=1 and clears dirty.
- UPLOAD->IDLE when ioctl_upload falls. That cycle clears dirty, unless a game write changed data during the upload (see below).
- Download/upload with a different index leaves FSM in IDLE and is ignored entirely.

RESTORE:
- ioctl_wr & in_range writes ioctl_dout to port B at ioctl_addr[AW-1:0].
- Out-of-range bytes are discarded.

UPLOAD:
- ioctl_rd samples ioctl_addr.
- ioctl_din is updated exactly 1 cycle after the ioctl_rd cycle, then held until the next ioctl_rd.
- Out-of-range addresses return 0xFF.

Game port:
- ea_dout <= mem[ea_addr] every cycle (1-cycle latency).
- A write updates mem on the same edge. A read of the same address on the next cycle returns the new data.

Dirty tracking:
- A game write sets dirty only if ea_din != current mem[ea_addr]. A compare pipeline is allowed, but dirty must be set no later than 2 cycles after the write.
- A changing write during UPLOAD sets a pending flag. At UPLOAD exit, dirty = pending, and the pending flag is then cleared.

Collision:
- A game write and an ioctl download write to the same address in the same cycle: the ioctl write wins.
- A game write and an upload read of the same address in the same cycle: ioctl_din returns the old data.

Autosave:
- The frame counter increments on each vblank rising edge while dirty=1 and FSM=IDLE.
- Any changing game write resets the counter to 0.
- When the counter reaches IDLE_FRAMES: save_req pulses for 1 cycle, the counter holds at 0, and no further pulse occurs until a new changing write followed by IDLE_FRAMES quiet frames.
- save_req never pulses outside IDLE.

Reset mid-operation:
- FSM returns to IDLE. dirty, pending, counter and restored are cleared. RAM is kept.
- A transfer still active after reset is ignored until its strobe falls.

Test Plan:
- Restore: download idx 4, addr 0..63 data = addr^0x5A -> restored=1 after fall. Game reads addr 10 -> ea_dout=0x50 one cycle later. dirty=0.
- Upload: after restore, ioctl_rd at addr 63 -> ioctl_din=0x65 on the next cycle. ioctl_rd at addr 64 -> 0xFF. Upload end -> dirty=0.
- Dirty/autosave: write 0x50 to addr 10 (unchanged) -> dirty stays 0. Write 0x11 -> dirty=1. After 60 vblank edges -> single save_req pulse. Write at frame 30 restarts the count.
- Write during upload: game writes a changed byte mid-upload -> dirty=1 after upload end. save_req 60 frames later.
- Wrong index: download idx 0 with data 0x00 -> RAM unchanged, restored=0. Upload idx 3 -> ioctl_din stays 0xFF.
- Reset mid-restore: assert reset after 20 bytes -> restored=0, bytes 0..19 hold new data, bytes 20..63 hold old data. No writes occur until ioctl_download falls.

Source files
------------

// File: rtl/nvram_ioctl_upload.sv
// nvram_ioctl_upload
//   NVRAM server for the 64-byte high-score EAROM. The game CPU uses port A.
//   The HPS ioctl path uses port B: downloads restore the image, and uploads
//   read it back out through ioctl_din for saving. The block tracks whether the
//   store differs from the last saved or restored image. After the game has
//   been quiet for IDLE_FRAMES frames, it pulses save_req for one cycle.
// Ports
//   clk_sys, reset        : system clock, synchronous active-high reset
//   ea_addr/ea_din/ea_wr  : game-side address, write data, write strobe
//   ea_dout               : game-side read data (1-cycle latency)
//   vblank                : frame timing for the autosave quiet period
//   ioctl_*               : hps_io download/upload interface
//   dirty                 : store differs from the last saved/restored image
//   save_req              : one-cycle autosave request
//   restored              : a complete restore has finished since reset
module nvram_ioctl_upload #(
  parameter int unsigned AW          = 6,
  parameter logic [7:0]  NV_INDEX    = 8'd4,
  parameter int unsigned IDLE_FRAMES = 60
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] ea_addr,
  input  logic [7:0]    ea_din,
  input  logic          ea_wr,
  output logic [7:0]    ea_dout,
  input  logic          vblank,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          dirty,
  output logic          save_req,
  output logic          restored
);

  localparam int unsigned DEPTH  = 1 << AW;
  localparam logic [7:0]  FRAMES = 8'(IDLE_FRAMES);

  typedef enum logic [1:0] {IDLE, RESTORE, UPLOAD} state_e;

  state_e        state_q, state_d;
  // The RAM holds inverted bytes, so its zeroed power-up state reads as 0xFF.
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    ea_dout_q, ioctl_din_q;
  logic          dirty_q, dirty_d;
  logic          pend_q, pend_d;
  logic          restored_q, restored_d;
  logic          save_q, save_d;
  logic          armed_q, armed_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          vblank_q;
  logic          blk_dl_q, blk_ul_q;

  logic          sel, in_range, dl_go, ul_go, dl_end, ul_end;
  logic          vb_rise, chg_wr, ram_wr, up_rd;
  logic [AW-1:0] ram_idx;
  logic [7:0]    ea_cur;

  assign sel      = (ioctl_index == NV_INDEX);
  assign in_range = (ioctl_addr[24:AW] == '0);
  assign ram_idx  = ioctl_addr[AW-1:0];
  assign ea_cur   = ~mem_q[ea_addr];

  // A transfer that was active during reset stays blocked until its strobe drops.
  assign dl_go  = (state_q == IDLE) & ioctl_download & sel & ~blk_dl_q;
  assign ul_go  = (state_q == IDLE) & ~dl_go & ioctl_upload & sel & ~blk_ul_q;
  assign dl_end = (state_q == RESTORE) & ~ioctl_download;
  assign ul_end = (state_q == UPLOAD) & ~ioctl_upload;

  assign vb_rise = vblank & ~vblank_q;
  assign chg_wr  = ea_wr & (ea_din != ea_cur);
  assign ram_wr  = ~reset & ioctl_wr & in_range &
                   (((state_q == RESTORE) & ioctl_download) | dl_go);
  assign up_rd   = ioctl_rd & (((state_q == UPLOAD) & ioctl_upload) | ul_go);

  always_comb begin
    state_d    = state_q;
    dirty_d    = dirty_q;
    pend_d     = pend_q;
    restored_d = restored_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    save_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dl_go)      state_d = RESTORE;
        else if (ul_go) state_d = UPLOAD;
      end
      RESTORE: if (dl_end) state_d = IDLE;
      UPLOAD:  if (ul_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A changing write restarts the quiet period and re-arms a single request.
    if (chg_wr) begin
      dirty_d = 1'b1;
      cnt_d   = '0;
      armed_d = 1'b1;
      if (state_q == UPLOAD) pend_d = 1'b1;
    end else if (vb_rise && dirty_q && armed_q && state_q == IDLE && !dl_go && !ul_go) begin
      if (cnt_q + 8'd1 == FRAMES) begin
        save_d  = 1'b1;
        cnt_d   = '0;
        armed_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (dl_end) begin
      restored_d = 1'b1;
      dirty_d    = 1'b0;
    end
    // The uploaded image is current unless the game changed it mid-upload.
    if (ul_end) begin
      dirty_d = pend_q | chg_wr;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      dirty_q    <= 1'b0;
      pend_q     <= 1'b0;
      restored_q <= 1'b0;
      save_q     <= 1'b0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      vblank_q   <= 1'b0;
      blk_dl_q   <= ioctl_download;
      blk_ul_q   <= ioctl_upload;
    end else begin
      state_q    <= state_d;
      dirty_q    <= dirty_d;
      pend_q     <= pend_d;
      restored_q <= restored_d;
      save_q     <= save_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      vblank_q   <= vblank;
      blk_dl_q   <= blk_dl_q & ioctl_download;
      blk_ul_q   <= blk_ul_q & ioctl_upload;
    end
  end

  // The ioctl write is issued last, so it wins a same-address collision.
  always_ff @(posedge clk_sys) begin
    if (ea_wr)  mem_q[ea_addr] <= ~ea_din;
    if (ram_wr) mem_q[ram_idx] <= ~ioctl_dout;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ea_dout_q   <= '0;
      ioctl_din_q <= '1;
    end else begin
      ea_dout_q <= ea_cur;
      if (up_rd) ioctl_din_q <= in_range ? ~mem_q[ram_idx] : 8'hFF;
    end
  end

  assign ea_dout   = ea_dout_q;
  assign ioctl_din = ioctl_din_q;
  assign dirty     = dirty_q;
  assign save_req  = save_q;
  assign restored  = restored_q;

endmodule

// File: tb/tb_nvram_ioctl_upload.sv
// tb_nvram_ioctl_upload
//   Scoreboard bench for nvram_ioctl_upload. Stimulus tasks update a
//   behavioural image of the store and its status, then queue the responses
//   they expect. A monitor pops a queue entry whenever the DUT presents a
//   response and compares it.
module tb_nvram_ioctl_upload;

  localparam int FR = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  ea_addr = '0;
  logic [7:0]  ea_din = '0;
  logic        ea_wr = 1'b0;
  logic [7:0]  ea_dout;
  logic        vblank = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_din;
  logic        dirty, save_req, restored;

  nvram_ioctl_upload #(.AW(6), .NV_INDEX(8'd4), .IDLE_FRAMES(FR)) dut (
    .clk_sys(clk), .reset(reset),
    .ea_addr(ea_addr), .ea_din(ea_din), .ea_wr(ea_wr), .ea_dout(ea_dout),
    .vblank(vblank),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .dirty(dirty), .save_req(save_req), .restored(restored)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dirty;
    logic       restored;
    int         saves;
    logic [7:0] din;
    bit         ea_chk;
    logic [7:0] ea;
  } st_t;

  logic [7:0] q_ea[$];
  logic [7:0] q_io[$];
  st_t        q_st[$];

  // Reference model of the store and its visible status.
  typedef enum {M_IDLE, M_RESTORE, M_UPLOAD} mode_e;
  logic [7:0] m_mem [64];
  bit         m_dirty, m_restored, m_pend, m_armed, m_blk_dl, m_blk_ul;
  int         m_frames, m_saves;
  logic [7:0] m_din;
  mode_e      m_mode;

  logic chk_ea = 1'b0, chk_st = 1'b0;
  logic pend_ea = 1'b0, pend_io = 1'b0, pend_st = 1'b0;
  logic save_prev = 1'b0;
  int   seen_saves = 0;
  int   vectors = 0;
  int   misc = 0;
  bit   done = 1'b0, final_done = 1'b0;

  // Monitor
  always @(posedge clk) begin
    pend_ea <= chk_ea;
    pend_io <= ioctl_rd;
    pend_st <= chk_st;
  end

  always @(negedge clk) begin
    logic [7:0] e;
    st_t s;
    if (save_req === 1'b1) begin
      seen_saves++;
      vectors++;
      if (save_prev === 1'b1) begin
        misc++;
        $display("FAIL save_req_width: got high on consecutive cycles, want a single-cycle pulse");
      end
    end
    save_prev = save_req;
    if (pend_ea) begin
      vectors++;
      if (q_ea.size() == 0) begin
        misc++;
        $display("FAIL ea_dout: response with no expectation queued (got %h)", ea_dout);
      end else begin
        e = q_ea.pop_front();
        if (ea_dout !== e) begin
          misc++;
          $display("FAIL ea_dout: got %h want %h", ea_dout, e);
        end
      end
    end
    if (pend_io) begin
      vectors++;
      if (q_io.size() == 0) begin
        misc++;
        $display("FAIL ioctl_din: response with no expectation queued (got %h)", ioctl_din);
      end else begin
        e = q_io.pop_front();
        if (ioctl_din !== e) begin
          misc++;
          $display("FAIL ioctl_din: got %h want %h", ioctl_din, e);
        end
      end
    end
    if (pend_st) begin
      if (q_st.size() == 0) begin
        vectors++;
        misc++;
        $display("FAIL status: check with no expectation queued");
      end else begin
        s = q_st.pop_front();
        vectors += 4;
        if (dirty !== s.dirty) begin
          misc++; $display("FAIL dirty: got %b want %b", dirty, s.dirty);
        end
        if (restored !== s.restored) begin
          misc++; $display("FAIL restored: got %b want %b", restored, s.restored);
        end
        if (seen_saves != s.saves) begin
          misc++; $display("FAIL save_count: got %0d want %0d", seen_saves, s.saves);
        end
        if (ioctl_din !== s.din) begin
          misc++; $display("FAIL din_hold: got %h want %h", ioctl_din, s.din);
        end
        if (s.ea_chk) begin
          vectors++;
          if (ea_dout !== s.ea) begin
            misc++; $display("FAIL ea_dout_reset: got %h want %h", ea_dout, s.ea);
          end
        end
      end
    end
    if (done && !final_done) begin
      vectors++;
      if (q_ea.size() + q_io.size() + q_st.size() != 0) begin
        misc++;
        $display("FAIL drain: %0d expectations never matched, want 0",
                 q_ea.size() + q_io.size() + q_st.size());
      end
      final_done = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not complete within the time limit");
    $fatal(1, "timeout");
  end

  // Stimulus tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_game_write(input int a, input logic [7:0] d);
    if (m_mem[a] != d) begin
      m_dirty  = 1'b1;
      m_frames = 0;
      m_armed  = 1'b1;
      if (m_mode == M_UPLOAD) m_pend = 1'b1;
    end
    m_mem[a] = d;
  endtask

  task automatic status(input bit ea_chk);
    st_t s;
    s.dirty = m_dirty; s.restored = m_restored; s.saves = m_saves;
    s.din = m_din; s.ea_chk = ea_chk; s.ea = 8'h00;
    q_st.push_back(s);
    chk_st = 1'b1;
    tick();
    chk_st = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    tick();
    m_dirty = 0; m_pend = 0; m_frames = 0; m_armed = 0; m_restored = 0;
    m_mode = M_IDLE; m_din = 8'hFF;
    m_blk_dl = ioctl_download; m_blk_ul = ioctl_upload;
    status(1'b1);
    reset = 1'b0;
    tick();
  endtask

  task automatic game_wr(input int a, input logic [7:0] d);
    ea_addr = 6'(a); ea_din = d; ea_wr = 1'b1;
    model_game_write(a, d);
    tick();
    ea_wr = 1'b0;
  endtask

  task automatic game_rd(input int a);
    ea_addr = 6'(a);
    chk_ea = 1'b1;
    q_ea.push_back(m_mem[a]);
    tick();
    chk_ea = 1'b0;
  endtask

  task automatic vblank_edge();
    vblank = 1'b1;
    if (m_mode == M_IDLE && m_dirty && m_armed) begin
      m_frames++;
      if (m_frames == FR) begin
        m_saves++;
        m_frames = 0;
        m_armed  = 1'b0;
      end
    end
    tick(); tick();
    vblank = 1'b0;
    tick(); tick();
  endtask

  task automatic vblanks(input int n);
    for (int i = 0; i < n; i++) vblank_edge();
  endtask

  task automatic dl_begin(input int idx);
    ioctl_index = 8'(idx);
    ioctl_download = 1'b1;
    if (idx == 4 && !m_blk_dl && m_mode == M_IDLE) m_mode = M_RESTORE;
    tick(); tick();
  endtask

  task automatic dl_byte(input int a, input logic [7:0] d, input bit gwr, input logic [7:0] gd);
    ioctl_addr = 25'(a); ioctl_dout = d; ioctl_wr = 1'b1;
    if (gwr) begin
      ea_addr = 6'(a); ea_din = gd; ea_wr = 1'b1;
      model_game_write(a % 64, gd);
    end
    if (m_mode == M_RESTORE && a < 64) m_mem[a] = d;
    tick();
    ioctl_wr = 1'b0; ea_wr = 1'b0;
    tick();
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    if (m_mode == M_RESTORE) begin
      m_restored = 1'b1;
      m_dirty    = 1'b0;
    end
    m_mode = M_IDLE; m_blk_dl = 1'b0;
    tick(); tick();
  endtask

  task automatic ul_begin(input int idx);
    ioctl_index = 8'(idx);
    ioctl_upload = 1'b1;
    if (idx == 4 && !m_blk_ul && m_mode == M_IDLE) m_mode = M_UPLOAD;
    tick(); tick();
  endtask

  task automatic ul_read(input int a, input bit gwr, input logic [7:0] gd);
    logic [7:0] e;
    ioctl_addr = 25'(a); ioctl_rd = 1'b1;
    if (m_mode == M_UPLOAD) e = (a < 64) ? m_mem[a] : 8'hFF;
    else e = m_din;
    m_din = e;
    q_io.push_back(e);
    if (gwr) begin
      ea_addr = 6'(a); ea_din = gd; ea_wr = 1'b1;
      model_game_write(a % 64, gd);
    end
    tick();
    ioctl_rd = 1'b0; ea_wr = 1'b0;
    tick();
  endtask

  task automatic ul_end();
    ioctl_upload = 1'b0;
    if (m_mode == M_UPLOAD) begin
      m_dirty = m_pend;
      m_pend  = 1'b0;
    end
    m_mode = M_IDLE; m_blk_ul = 1'b0;
    tick(); tick();
  endtask

  initial begin
    int op, a;
    logic [7:0] d;
    for (int i = 0; i < 64; i++) m_mem[i] = 8'hFF;
    m_saves = 0;

    // Reset state and power-up contents
    reset_pulse();
    game_rd(5);
    game_rd(63);

    // Wrong index download is ignored entirely
    dl_begin(0);
    for (int i = 0; i < 64; i += 9) dl_byte(i, 8'h00, 1'b0, 8'h00);
    dl_end();
    status(1'b0);
    game_rd(0);
    game_rd(9);

    // Full restore, plus out-of-range bytes that must be discarded
    dl_begin(4);
    for (int i = 0; i < 64; i++) dl_byte(i, 8'(i) ^ 8'h5A, 1'b0, 8'h00);
    dl_byte(64, 8'h00, 1'b0, 8'h00);
    dl_byte(65, 8'h01, 1'b0, 8'h00);
    dl_end();
    status(1'b0);
    game_rd(10);
    game_rd(0);
    game_rd(1);

    // Upload including out-of-range addresses
    ul_begin(4);
    ul_read(63, 1'b0, 8'h00);
    ul_read(64, 1'b0, 8'h00);
    ul_read(25'h1FFFFFF, 1'b0, 8'h00);
    ul_read(10, 1'b0, 8'h00);
    ul_end();
    status(1'b0);

    // Wrong index upload holds ioctl_din
    ul_begin(3);
    ul_read(5, 1'b0, 8'h00);
    ul_end();

    // Dirty tracking and autosave with a restart at frame 30
    game_wr(10, 8'h50);
    status(1'b0);
    game_wr(10, 8'h11);
    status(1'b0);
    game_rd(10);
    vblanks(30);
    game_wr(12, 8'h99);
    vblanks(FR - 1);
    status(1'b0);
    vblanks(1);
    status(1'b0);
    vblanks(70);
    status(1'b0);

    // Changing write during upload, including a same-address collision
    ul_begin(4);
    ul_read(10, 1'b0, 8'h00);
    ul_read(20, 1'b1, 8'hEE);
    ul_end();
    status(1'b0);
    game_rd(20);
    vblanks(FR - 1);
    status(1'b0);
    vblanks(1);
    status(1'b0);
    ul_begin(4);
    ul_read(20, 1'b0, 8'h00);
    ul_end();
    status(1'b0);

    // Restore with a colliding game write: ioctl data wins
    dl_begin(4);
    for (int i = 0; i < 64; i++) dl_byte(i, 8'(i) ^ 8'h33, i == 7, 8'h00);
    dl_end();
    status(1'b0);
    game_rd(7);

    // Randomised game traffic
    for (int i = 0; i < 160; i++) begin
      op = $urandom_range(0, 9);
      a  = $urandom_range(0, 63);
      d  = ($urandom_range(0, 1) == 1) ? m_mem[a] : 8'($urandom);
      case (op)
        0, 1, 2: game_wr(a, d);
        3, 4, 5: game_rd(a);
        6, 7:    vblank_edge();
        default: status(1'b0);
      endcase
    end
    for (int k = 0; k < 4; k++) begin
      ul_begin(4);
      for (int j = 0; j < 4; j++) begin
        a = $urandom_range(0, 70);
        ul_read(a, ($urandom_range(0, 3) == 0) && (a < 64), 8'($urandom));
      end
      ul_end();
      status(1'b0);
    end

    // Reset in the middle of a restore
    dl_begin(4);
    for (int i = 0; i < 20; i++) dl_byte(i, 8'(i) ^ 8'hC3, 1'b0, 8'h00);
    reset_pulse();
    for (int i = 20; i < 64; i++) dl_byte(i, 8'h77, 1'b0, 8'h00);
    dl_end();
    status(1'b0);
    for (int i = 0; i < 64; i++) game_rd(i);

    // Uploads after the reset: wrong index keeps 0xFF, right index works
    ul_begin(3);
    ul_read(5, 1'b0, 8'h00);
    ul_end();
    ul_begin(4);
    ul_read(0, 1'b0, 8'h00);
    ul_read(19, 1'b0, 8'h00);
    ul_end();
    status(1'b0);

    tick(); tick(); tick();
    done = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
